keyword_match_multi: RTL

Streaming multi-keyword matcher for the keyword-search path: it replaces the fixed four-keyword, hard-coded top with NUM_KW runtime-loadable keywords of up to KW_BYTES bytes each. It consumes one AXI-Stream text frame and finds keyword occurrences that span beat boundaries. At end of frame it reports a per-keyword hit bitmap plus a match/no-match/error verdict to access control, held until acknowledged. It sits between the text DMA stream and the access-control logic.

---
 rtl/keyword_match_pkg.sv | 24 ++
 rtl/kw_match_lane.sv | 59 +++++
 rtl/keyword_match_multi.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/keyword_match_pkg.sv
// Shared state encoding and width helpers for the multi-keyword matcher.
// Widths are derived from the top parameters so every file agrees on them.
package keyword_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MATCH  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int len_width(input int kw_bytes);
        return $clog2(kw_bytes + 1);
    endfunction

    // Never below 1 so a single-slot build still has a legal address port.
    function automatic int addr_width(input int num_kw);
        return (num_kw > 1) ? $clog2(num_kw) : 1;
    endfunction

endpackage

// File: rtl/kw_match_lane.sv
// One keyword slot: compares every kept end position of the beat against the keyword.
// Zero latency to hit_nxt; the sticky bit only advances on an accepted beat.
module kw_match_lane
    import keyword_match_pkg::*;
#(
    parameter  int KW_BYTES   = 16,
    parameter  int KEEP_WIDTH = 8,
    parameter  int LEN_W      = 5,
    localparam int HIST       = KW_BYTES - 1,
    localparam int WIN        = HIST + KEEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*WIN-1:0]      win_dat,
    input  logic [WIN-1:0]        win_vld,
    input  logic [8*KW_BYTES-1:0] kw_dat,
    input  logic [LEN_W-1:0]      kw_len,
    input  logic                  beat_acc,
    input  logic                  first_beat,
    output logic                  hit_nxt
);

    logic hit_q;
    logic hit_beat;
    logic ok;

    // Lengths outside 1..KW_BYTES never select a comparator, so such slots stay silent.
    always_comb begin
        hit_beat = 1'b0;
        ok       = 1'b0;
        for (int p = 0; p < KEEP_WIDTH; p++) begin
            for (int l = 1; l <= KW_BYTES; l++) begin
                if (kw_len == LEN_W'(l)) begin
                    ok = 1'b1;
                    for (int i = 0; i < l; i++) begin
                        if (!win_vld[HIST + p - l + 1 + i] ||
                            (win_dat[8*(HIST + p - l + 1 + i) +: 8] != kw_dat[8*i +: 8])) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        hit_beat = 1'b1;
                    end
                end
            end
        end
    end

    assign hit_nxt = (hit_q & ~first_beat) | hit_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= 1'b0;
        end else if (beat_acc) begin
            hit_q <= hit_nxt;
        end
    end

endmodule

// File: rtl/keyword_match_multi.sv
// Streaming matcher for NUM_KW loadable keywords; verdict registered on the tlast edge, held until ack.
// Backpressure: tready drops for the whole REPORT phase; table writes only land while IDLE.
module keyword_match_multi
    import keyword_match_pkg::*;
#(
    parameter  int NUM_KW     = 4,
    parameter  int KW_BYTES   = 16,
    parameter  int DATA_WIDTH = 64,
    localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
    localparam int LEN_W      = len_width(KW_BYTES),
    localparam int ADDR_W     = addr_width(NUM_KW)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_text_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_text_tkeep,
    input  logic                  s_axis_text_tvalid,
    output logic                  s_axis_text_tready,
    input  logic                  s_axis_text_tlast,
    input  logic                  s_axis_text_tuser,
    input  logic                  kw_wr_en,
    input  logic [ADDR_W-1:0]     kw_wr_addr,
    input  logic [8*KW_BYTES-1:0] kw_wr_data,
    input  logic [LEN_W-1:0]      kw_wr_len,
    output logic                  kw_wr_ready,
    output logic                  match_sig,
    output logic                  no_match_sig,
    output logic                  err_sig,
    output logic [NUM_KW-1:0]     match_map,
    input  logic                  ack
);

    localparam int HIST  = KW_BYTES - 1;
    localparam int WIN   = HIST + KEEP_WIDTH;
    localparam int CNT_W = $clog2(KW_BYTES);
    localparam int KN_W  = $clog2(KEEP_WIDTH + 1);

    state_t state, state_nxt;
    logic   started_q;

    logic [8*KW_BYTES-1:0] kw_dat [NUM_KW];
    logic [LEN_W-1:0]      kw_len [NUM_KW];

    logic [8*HIST-1:0] hist_dat;
    logic [8*HIST-1:0] hist_nxt;
    logic [CNT_W-1:0]  hist_cnt;
    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  cnt_nxt;
    int                cnt_sum;
    logic [KN_W-1:0]   keep_n;
    logic              err_acc;
    logic              frame_err;

    logic [8*WIN-1:0]  win_dat;
    logic [WIN-1:0]    win_vld;
    logic [NUM_KW-1:0] hit_nxt;
    logic              beat_acc;
    logic              first_beat;
    logic              last_acc;

    // tready stays low through reset and comes up on the first clock after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    assign s_axis_text_tready = started_q && (state != ST_REPORT);
    assign kw_wr_ready        = (state == ST_IDLE);
    assign beat_acc           = s_axis_text_tvalid && s_axis_text_tready;
    assign first_beat         = (state == ST_IDLE);
    assign last_acc           = beat_acc && s_axis_text_tlast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (beat_acc) begin
                    state_nxt = s_axis_text_tlast ? ST_REPORT : ST_MATCH;
                end
            end
            ST_MATCH: begin
                if (last_acc) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A write racing a first beat lands at the same edge, so the lanes still see the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_KW; s++) begin
                kw_dat[s] <= '0;
                kw_len[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_KW; s++) begin
                if (kw_wr_en && kw_wr_ready && (kw_wr_addr == ADDR_W'(s))) begin
                    kw_dat[s] <= kw_wr_data;
                    kw_len[s] <= kw_wr_len;
                end
            end
        end
    end

    // Window = history (oldest at byte 0) followed by the current beat.
    assign cnt_eff = first_beat ? '0 : hist_cnt;
    assign win_dat = {s_axis_text_tdata, hist_dat};

    always_comb begin
        win_vld = '0;
        for (int j = 0; j < HIST; j++) begin
            win_vld[j] = (j >= (HIST - int'(cnt_eff)));
        end
        win_vld[WIN-1:HIST] = s_axis_text_tkeep;
    end

    always_comb begin
        keep_n = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            keep_n = keep_n + KN_W'(s_axis_text_tkeep[k]);
        end
    end

    // Kept bytes are low-aligned, so the new history is the window shifted by the kept count.
    always_comb begin
        hist_nxt = '0;
        for (int j = 0; j < HIST; j++) begin
            hist_nxt[8*j +: 8] = win_dat[8*(j + int'(keep_n)) +: 8];
        end
        cnt_sum = int'(cnt_eff) + int'(keep_n);
        cnt_nxt = (cnt_sum >= HIST) ? CNT_W'(HIST) : CNT_W'(cnt_sum);
    end

    assign frame_err = (err_acc && !first_beat) || s_axis_text_tuser;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_dat <= '0;
            hist_cnt <= '0;
            err_acc  <= 1'b0;
        end else if (beat_acc) begin
            hist_dat <= hist_nxt;
            hist_cnt <= cnt_nxt;
            err_acc  <= frame_err;
        end
    end

    for (genvar s = 0; s < NUM_KW; s++) begin : g_lane
        kw_match_lane #(
            .KW_BYTES   (KW_BYTES),
            .KEEP_WIDTH (KEEP_WIDTH),
            .LEN_W      (LEN_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .win_dat    (win_dat),
            .win_vld    (win_vld),
            .kw_dat     (kw_dat[s]),
            .kw_len     (kw_len[s]),
            .beat_acc   (beat_acc),
            .first_beat (first_beat),
            .hit_nxt    (hit_nxt[s])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_sig    <= 1'b0;
            no_match_sig <= 1'b0;
            err_sig      <= 1'b0;
            match_map    <= '0;
        end else if ((state == ST_REPORT) && ack) begin
            match_sig    <= 1'b0;
            no_match_sig <= 1'b0;
            err_sig      <= 1'b0;
            match_map    <= '0;
        end else if (last_acc) begin
            err_sig      <= frame_err;
            match_map    <= frame_err ? '0 : hit_nxt;
            match_sig    <= !frame_err && (|hit_nxt);
            no_match_sig <= !frame_err && !(|hit_nxt);
        end
    end

endmodule
